// File: rtl/cam_axis_rx.sv
`default_nettype none
// ============================================================================
// Module   : cam_axis_rx
// Purpose  : Frame-aligns a free-running hcount/vcount/pixel camera stream and
//            re-emits it as an AXI4-Stream video master through a small FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module cam_axis_rx #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          n_rst,
    input  logic [$clog2(IMG_WIDTH)-1:0]  hcount,
    input  logic [$clog2(IMG_HEIGHT)-1:0] vcount,
    input  logic [DATA_WIDTH-1:0]         din,
    input  logic                          en,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tuser,
    output logic                          m_axis_tlast,
    output logic                          overflow,
    output logic [15:0]                   frame_cnt
);

    localparam int HW = $clog2(IMG_WIDTH);
    localparam int VW = $clog2(IMG_HEIGHT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = DATA_WIDTH + 2;

    localparam logic [HW:0]   H_LIM    = (HW+1)'(IMG_WIDTH);
    localparam logic [VW:0]   V_LIM    = (VW+1)'(IMG_HEIGHT);
    localparam logic [HW-1:0] LAST_COL = HW'(IMG_WIDTH - 1);
    localparam logic [VW-1:0] LAST_ROW = VW'(IMG_HEIGHT - 1);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_SOF = 2'd1,
        S_STREAM   = 2'd2,
        S_DROP     = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Input sample register
    // ------------------------------------------------------------------
    logic [HW-1:0]         h_q;
    logic [VW-1:0]         v_q;
    logic [DATA_WIDTH-1:0] d_q;
    logic                  in_range_q;
    logic                  in_range_d;

    assign in_range_d = ({1'b0, hcount} < H_LIM) && ({1'b0, vcount} < V_LIM);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            h_q        <= '0;
            v_q        <= '0;
            d_q        <= '0;
            in_range_q <= 1'b0;
        end else begin
            h_q        <= hcount;
            v_q        <= vcount;
            d_q        <= din;
            in_range_q <= in_range_d;
        end
    end

    logic w_sof;
    logic w_eol;
    logic w_eof;

    assign w_sof = in_range_q && (h_q == '0) && (v_q == '0);
    assign w_eol = in_range_q && (h_q == LAST_COL);
    assign w_eof = w_eol && (v_q == LAST_ROW);

    // ------------------------------------------------------------------
    // Frame-alignment FSM
    // ------------------------------------------------------------------
    state_t state_q;
    state_t state_d;
    logic   push_try;
    logic   push;
    logic   pop;
    logic   ovf_set;
    logic   frame_inc;
    logic   fifo_full;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        push_try  = 1'b0;
        ovf_set   = 1'b0;
        frame_inc = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (en) begin
                    state_d = S_WAIT_SOF;
                end
            end
            S_WAIT_SOF: begin
                if (!en) begin
                    state_d = S_IDLE;
                end else if (w_sof) begin
                    push_try = 1'b1;
                end
            end
            S_STREAM: begin
                push_try = in_range_q;
            end
            S_DROP: begin
                if (w_sof) begin
                    if (en) begin
                        push_try = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Full is judged before any same-cycle pop, so a full FIFO always drops.
        if (push_try) begin
            if (fifo_full) begin
                ovf_set = 1'b1;
                state_d = S_DROP;
            end else if (w_eof) begin
                frame_inc = 1'b1;
                state_d   = en ? S_STREAM : S_IDLE;
            end else begin
                state_d = S_STREAM;
            end
        end
    end

    assign push = push_try && !fifo_full;

    // ------------------------------------------------------------------
    // Status
    // ------------------------------------------------------------------
    logic        overflow_q;
    logic [15:0] frame_cnt_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            overflow_q  <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            if (ovf_set) begin
                overflow_q <= 1'b1;
            end
            if (frame_inc) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
        end
    end

    assign overflow  = overflow_q;
    assign frame_cnt = frame_cnt_q;

    // ------------------------------------------------------------------
    // Output FIFO, first-word fall-through; entry = {tuser, tlast, data}
    // ------------------------------------------------------------------
    logic [EW-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic [EW-1:0] head;

    assign fifo_full = (count_q == FULL_CNT);
    assign pop       = m_axis_tvalid && m_axis_tready;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {w_sof, w_eol, d_q};
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Outputs are masked with tvalid so a reset clears them without clearing memory.
    assign head          = mem_q[rd_ptr_q];
    assign m_axis_tvalid = (count_q != '0);
    assign m_axis_tdata  = m_axis_tvalid ? head[DATA_WIDTH-1:0] : '0;
    assign m_axis_tlast  = m_axis_tvalid && head[DATA_WIDTH];
    assign m_axis_tuser  = m_axis_tvalid && head[DATA_WIDTH+1];

endmodule
`default_nettype wire

// File: tb/tb_cam_axis_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_cam_axis_rx
// Purpose  : Directed self-checking bench for cam_axis_rx on a 4x3 frame.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cam_axis_rx;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int DW = 8;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          n_rst;
    logic [1:0]    hcount;
    logic [1:0]    vcount;
    logic [DW-1:0] din;
    logic          en;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tuser;
    logic          m_axis_tlast;
    logic          overflow;
    logic [15:0]   frame_cnt;

    always #5 clk = ~clk;

    cam_axis_rx #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (D)
    ) u_dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .hcount        (hcount),
        .vcount        (vcount),
        .din           (din),
        .en            (en),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tlast  (m_axis_tlast),
        .overflow      (overflow),
        .frame_cnt     (frame_cnt)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Beat capture and hold-stability checking
    logic [9:0] beats[$];
    logic       hold_q     = 1'b0;
    logic [9:0] held_q     = '0;
    logic       chk_stable = 1'b0;
    logic       toggle     = 1'b0;

    always @(negedge clk) begin
        if (chk_stable && hold_q) begin
            check("hold_valid", 32'(m_axis_tvalid), 32'd1);
            check("hold_beat", 32'({m_axis_tuser, m_axis_tlast, m_axis_tdata}), 32'(held_q));
        end
        if (n_rst && m_axis_tvalid && m_axis_tready) begin
            beats.push_back({m_axis_tuser, m_axis_tlast, m_axis_tdata});
        end
        hold_q <= n_rst && m_axis_tvalid && !m_axis_tready;
        held_q <= {m_axis_tuser, m_axis_tlast, m_axis_tdata};
    end

    task automatic pix(input int h, input int v, input logic [7:0] d);
        @(posedge clk);
        #1;
        hcount = 2'(h);
        vcount = 2'(v);
        din    = d;
        if (toggle) begin
            m_axis_tready = ~m_axis_tready;
        end
    endtask

    // Row 3 is outside the 3-line frame, so these samples are blanking.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            pix(0, 3, 8'hEE);
        end
    endtask

    task automatic send_frame(input int base, input int blank, input int eh, input int ev,
                              input logic ev_val);
        logic [7:0] dd;
        for (int v = 0; v < H; v++) begin
            for (int h = 0; h < W; h++) begin
                if (h == eh && v == ev) begin
                    en = ev_val;
                end
                dd = 8'(base + v * W + h);
                pix(h, v, dd);
            end
            idle(blank);
        end
    endtask

    // Expected beat i of a frame: data base+i, tuser on first, tlast every 4th.
    task automatic chk_beats(input string tag, input int start, input int base, input int n);
        logic [9:0] e;
        for (int i = 0; i < n; i++) begin
            e = {(i == 0), (i % W == W - 1), 8'(base + i)};
            if (start + i < beats.size()) begin
                check(tag, 32'(beats[start + i]), 32'(e));
            end
        end
    endtask

    initial begin
        n_rst         = 1'b0;
        en            = 1'b0;
        m_axis_tready = 1'b1;
        hcount        = '0;
        vcount        = '0;
        din           = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("rst_tdata", 32'(m_axis_tdata), 32'd0);
        check("rst_tuser", 32'(m_axis_tuser), 32'd0);
        check("rst_tlast", 32'(m_axis_tlast), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        n_rst = 1'b1;

        // Idle: capture disabled for two frames
        send_frame(8'h20, 0, -1, -1, 1'b0);
        send_frame(8'h20, 0, -1, -1, 1'b0);
        idle(4);
        check("idle_beats", 32'(beats.size()), 32'd0);
        check("idle_frame_cnt", 32'(frame_cnt), 32'd0);

        // Alignment: enable mid-frame, stream next frame, disable during it
        beats.delete();
        send_frame(8'h10, 0, 2, 1, 1'b1);
        send_frame(8'h40, 0, 1, 1, 1'b0);
        send_frame(8'h80, 0, -1, -1, 1'b0);
        idle(4);
        check("align_count", 32'(beats.size()), 32'd12);
        chk_beats("align_beat", 0, 8'h40, 12);
        check("align_frame_cnt", 32'(frame_cnt), 32'd1);

        // Same with horizontal blanking samples between lines
        beats.delete();
        send_frame(8'h10, 3, 2, 1, 1'b1);
        send_frame(8'h60, 3, 1, 1, 1'b0);
        send_frame(8'h80, 3, -1, -1, 1'b0);
        idle(4);
        check("blank_count", 32'(beats.size()), 32'd12);
        chk_beats("blank_beat", 0, 8'h60, 12);
        check("blank_frame_cnt", 32'(frame_cnt), 32'd2);

        // Overflow: stall from SOF, frame truncated after 4 entries
        beats.delete();
        send_frame(8'h10, 0, 0, 2, 1'b1);
        m_axis_tready = 1'b0;
        send_frame(8'h50, 0, -1, -1, 1'b1);
        @(negedge clk);
        check("ovf_tvalid", 32'(m_axis_tvalid), 32'd1);
        check("ovf_tdata", 32'(m_axis_tdata), 32'h50);
        check("ovf_tuser", 32'(m_axis_tuser), 32'd1);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_frame_cnt", 32'(frame_cnt), 32'd2);
        m_axis_tready = 1'b1;
        idle(8);
        // Recovery frame, disabled at (1,1) so it completes then stops; re-enable on D's last pixel
        send_frame(8'h90, 0, 1, 1, 1'b0);
        send_frame(8'hA0, 0, 3, 2, 1'b1);
        idle(6);
        check("ovf_count", 32'(beats.size()), 32'd16);
        chk_beats("ovf_drain", 0, 8'h50, 4);
        chk_beats("ovf_recover", 4, 8'h90, 12);
        check("ovf_frame_cnt2", 32'(frame_cnt), 32'd3);
        check("ovf_sticky", 32'(overflow), 32'd1);

        // Back-pressure: tready toggles every cycle during a blanked frame
        beats.delete();
        toggle     = 1'b1;
        chk_stable = 1'b1;
        send_frame(8'hB0, 4, 1, 1, 1'b0);
        toggle        = 1'b0;
        m_axis_tready = 1'b1;
        idle(8);
        chk_stable = 1'b0;
        check("bp_count", 32'(beats.size()), 32'd12);
        chk_beats("bp_beat", 0, 8'hB0, 12);
        check("bp_frame_cnt", 32'(frame_cnt), 32'd4);

        // Asynchronous reset in the middle of a stalled frame
        en            = 1'b1;
        m_axis_tready = 1'b0;
        idle(3);
        for (int i = 0; i < 8; i++) begin
            pix(i % W, i / W, 8'(8'hC0 + i));
        end
        @(negedge clk);
        check("mid_tvalid", 32'(m_axis_tvalid), 32'd1);
        check("mid_overflow", 32'(overflow), 32'd1);
        n_rst = 1'b0;
        #1;
        check("arst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("arst_tdata", 32'(m_axis_tdata), 32'd0);
        check("arst_tuser", 32'(m_axis_tuser), 32'd0);
        check("arst_tlast", 32'(m_axis_tlast), 32'd0);
        check("arst_overflow", 32'(overflow), 32'd0);
        check("arst_frame_cnt", 32'(frame_cnt), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        n_rst = 1'b1;
        en    = 1'b0;
        idle(3);
        check("post_rst_tvalid", 32'(m_axis_tvalid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
